// File: rtl/mutex_req_pkg.sv
// Shared types and default parameters for the two-channel mutex client.
package mutex_req_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OWN  = 2'd2,
    REL  = 2'd3
  } chan_state_t;

  localparam int DEFAULT_HOLD_W      = 8;
  localparam int DEFAULT_TIMEOUT     = 64;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/mutex_req_chan.sv
// One mutex client channel: grant synchroniser, four-phase handshake FSM,
// wait/hold counters and per-cycle protocol-violation indication.
module mutex_req_chan
  import mutex_req_pkg::*;
#(
  parameter int HOLD_W      = DEFAULT_HOLD_W,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic              g,
  output logic              r,
  output logic              own,
  output logic              busy,
  output logic              done,
  output logic              tmo,
  output logic              gs,
  output logic              spur
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [SYNC_STAGES-1:0] sync_reg;
  chan_state_t            state_reg;
  logic [WAIT_W-1:0]      wait_reg;
  logic [HOLD_W-1:0]      hold_len_reg;
  logic [HOLD_W-1:0]      hold_cnt_reg;
  logic                   from_own_reg;
  logic                   r_reg;
  logic                   own_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   tmo_reg;

  // The grant is asynchronous to clk; only the last stage is ever consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], g};
    end
  end

  assign gs = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_reg     <= '0;
      hold_len_reg <= '0;
      hold_cnt_reg <= '0;
      from_own_reg <= 1'b0;
      r_reg        <= 1'b0;
      own_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      tmo_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      tmo_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= REQ;
            hold_len_reg <= hold_len;
            wait_reg     <= '0;
            r_reg        <= 1'b1;
            busy_reg     <= 1'b1;
          end
        end
        REQ: begin
          if (gs) begin
            state_reg    <= OWN;
            hold_cnt_reg <= (hold_len_reg == '0) ? HOLD_ONE : hold_len_reg;
            own_reg      <= 1'b1;
          end else if (wait_reg == WAIT_MAX) begin
            // Request abandoned; the mutex may still grant late, which REL absorbs.
            state_reg    <= REL;
            wait_reg     <= '0;
            from_own_reg <= 1'b0;
            r_reg        <= 1'b0;
            tmo_reg      <= 1'b1;
          end else begin
            wait_reg <= wait_reg + 1'b1;
          end
        end
        OWN: begin
          hold_cnt_reg <= hold_cnt_reg - HOLD_ONE;
          if (hold_cnt_reg == HOLD_ONE) begin
            state_reg    <= REL;
            wait_reg     <= '0;
            from_own_reg <= 1'b1;
            r_reg        <= 1'b0;
            own_reg      <= 1'b0;
          end
        end
        REL: begin
          if (!gs) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= from_own_reg;
          end else if (wait_reg == WAIT_MAX) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            tmo_reg   <= 1'b1;
          end else begin
            wait_reg <= wait_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A grant seen while idle, or lost while owning, is a mutex fault.
  assign spur = ((state_reg == IDLE) && gs) || ((state_reg == OWN) && !gs);

  assign r    = r_reg;
  assign own  = own_reg;
  assign busy = busy_reg;
  assign done = done_reg;
  assign tmo  = tmo_reg;

endmodule

// File: rtl/mutex_requester.sv
// Two independent mutex client channels plus sticky mutual-exclusion and
// spurious-grant error flags built from the synchronised grants.
module mutex_requester
  import mutex_req_pkg::*;
#(
  parameter int HOLD_W      = DEFAULT_HOLD_W,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start1,
  input  logic              start2,
  input  logic [HOLD_W-1:0] hold_len1,
  input  logic [HOLD_W-1:0] hold_len2,
  output logic              r1,
  output logic              r2,
  input  logic              g1,
  input  logic              g2,
  output logic              own1,
  output logic              own2,
  output logic              busy1,
  output logic              busy2,
  output logic              done1,
  output logic              done2,
  output logic              tmo1,
  output logic              tmo2,
  output logic              err_both,
  output logic              err_spur
);

  logic [1:0]        start_vec;
  logic [1:0]        g_vec;
  logic [HOLD_W-1:0] hold_vec [2];
  logic [1:0]        r_vec;
  logic [1:0]        own_vec;
  logic [1:0]        busy_vec;
  logic [1:0]        done_vec;
  logic [1:0]        tmo_vec;
  logic [1:0]        gs_vec;
  logic [1:0]        spur_vec;
  logic              err_both_reg;
  logic              err_spur_reg;

  assign start_vec   = {start2, start1};
  assign g_vec       = {g2, g1};
  assign hold_vec[0] = hold_len1;
  assign hold_vec[1] = hold_len2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      mutex_req_chan #(
        .HOLD_W      (HOLD_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
        .clk      (clk),
        .reset    (reset),
        .start    (start_vec[gi]),
        .hold_len (hold_vec[gi]),
        .g        (g_vec[gi]),
        .r        (r_vec[gi]),
        .own      (own_vec[gi]),
        .busy     (busy_vec[gi]),
        .done     (done_vec[gi]),
        .tmo      (tmo_vec[gi]),
        .gs       (gs_vec[gi]),
        .spur     (spur_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      err_both_reg <= 1'b0;
      err_spur_reg <= 1'b0;
    end else begin
      err_both_reg <= err_both_reg | (&gs_vec);
      err_spur_reg <= err_spur_reg | (|spur_vec);
    end
  end

  assign r1       = r_vec[0];
  assign r2       = r_vec[1];
  assign own1     = own_vec[0];
  assign own2     = own_vec[1];
  assign busy1    = busy_vec[0];
  assign busy2    = busy_vec[1];
  assign done1    = done_vec[0];
  assign done2    = done_vec[1];
  assign tmo1     = tmo_vec[0];
  assign tmo2     = tmo_vec[1];
  assign err_both = err_both_reg;
  assign err_spur = err_spur_reg;

endmodule

// File: tb/tb_mutex_requester.sv
// Directed bench: a small behavioural mutex drives g1/g2 from r1/r2 while
// transaction timing and error flags are checked against hand-derived values.
module tb_mutex_requester;

  localparam int HOLD_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start1 = 1'b0, start2 = 1'b0;
  logic [HOLD_W-1:0] hold_len1 = '0, hold_len2 = '0;
  logic              g1 = 1'b0, g2 = 1'b0;
  logic              r1, r2, own1, own2, busy1, busy2;
  logic              done1, done2, tmo1, tmo2, err_both, err_spur;

  int checks = 0;
  int errors = 0;

  // behavioural mutex and per-test statistics
  int cyc, dly, rcnt1, rcnt2;
  logic grant_en, force_g2;
  int own_cnt1, own_cnt2, own_first1, own_first2, overlap;
  int done_cnt1, done_cnt2, done_at1, done_at2, tmo_cnt1, tmo_at1, r2_hi;

  mutex_requester #(
    .HOLD_W      (HOLD_W),
    .TIMEOUT     (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start1    (start1),
    .start2    (start2),
    .hold_len1 (hold_len1),
    .hold_len2 (hold_len2),
    .r1        (r1),
    .r2        (r2),
    .g1        (g1),
    .g2        (g2),
    .own1      (own1),
    .own2      (own2),
    .busy1     (busy1),
    .busy2     (busy2),
    .done1     (done1),
    .done2     (done2),
    .tmo1      (tmo1),
    .tmo2      (tmo2),
    .err_both  (err_both),
    .err_spur  (err_spur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; rcnt1 = 0; rcnt2 = 0;
    own_cnt1 = 0; own_cnt2 = 0; own_first1 = -1; own_first2 = -1; overlap = 0;
    done_cnt1 = 0; done_cnt2 = 0; done_at1 = -1; done_at2 = -1;
    tmo_cnt1 = 0; tmo_at1 = -1; r2_hi = 0;
  endtask

  // One clock: observe outputs just after the edge, then update the mutex model.
  task automatic step();
    logic ng1, ng2;
    @(posedge clk);
    #1;
    cyc++;
    start1 = 1'b0;
    start2 = 1'b0;
    if (own1) begin own_cnt1++; if (own_first1 < 0) own_first1 = cyc; end
    if (own2) begin own_cnt2++; if (own_first2 < 0) own_first2 = cyc; end
    if (own1 && own2) overlap++;
    if (done1) begin done_cnt1++; done_at1 = cyc; end
    if (done2) begin done_cnt2++; done_at2 = cyc; end
    if (tmo1) begin tmo_cnt1++; tmo_at1 = cyc; end
    if (r2) r2_hi++;
    rcnt1 = r1 ? rcnt1 + 1 : 0;
    rcnt2 = r2 ? rcnt2 + 1 : 0;
    ng1 = 1'b0;
    ng2 = 1'b0;
    if (grant_en) begin
      ng1 = r1 && (g1 || (!g2 && rcnt1 >= dly));
      ng2 = r2 && (g2 || (!ng1 && rcnt2 >= dly));
    end
    g1 = ng1;
    g2 = ng2 | force_g2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] outs();
    return {20'd0, r1, r2, own1, own2, busy1, busy2, done1, done2,
            tmo1, tmo2, err_both, err_spur};
  endfunction

  initial begin
    grant_en = 1'b1; force_g2 = 1'b0; dly = 1;
    clear_stats();

    // reset state
    reset = 1'b1;
    steps(2);
    chk("reset_outs", outs(), 32'd0);
    reset = 1'b0;
    steps(1);
    $display("txn reset: outputs=%0h", outs());

    // single request, grant after 2 cycles, hold 3
    clear_stats(); dly = 3;
    hold_len1 = 8'd3; start1 = 1'b1;
    step();
    chk("single_r1_c1", r1, 1);
    chk("single_busy1_c1", busy1, 1);
    steps(19);
    chk("single_own_first", own_first1, 6);
    chk("single_own_cnt", own_cnt1, 3);
    chk("single_done_cnt", done_cnt1, 1);
    chk("single_done_at", done_at1, 12);
    chk("single_r2_quiet", r2_hi, 0);
    $display("txn single: own_first=%0d own_cycles=%0d done_at=%0d", own_first1, own_cnt1, done_at1);

    // contention, both start together, hold 5
    clear_stats(); dly = 1;
    hold_len1 = 8'd5; hold_len2 = 8'd5; start1 = 1'b1; start2 = 1'b1;
    steps(25);
    chk("cont_overlap", overlap, 0);
    chk("cont_own1_cnt", own_cnt1, 5);
    chk("cont_own2_cnt", own_cnt2, 5);
    chk("cont_own1_first", own_first1, 4);
    chk("cont_own2_first", own_first2, 12);
    chk("cont_done1_at", done_at1, 12);
    chk("cont_done2_at", done_at2, 20);
    chk("cont_done_cnt", done_cnt1 + done_cnt2, 2);
    chk("cont_err_both", err_both, 0);
    chk("cont_err_spur", err_spur, 0);
    $display("txn contention: own1=%0d@%0d own2=%0d@%0d done1@%0d done2@%0d",
             own_cnt1, own_first1, own_cnt2, own_first2, done_at1, done_at2);

    // request timeout with the grant never given (TIMEOUT=16)
    clear_stats(); grant_en = 1'b0;
    hold_len1 = 8'd3; start1 = 1'b1;
    steps(25);
    chk("tmo_at", tmo_at1, 17);
    chk("tmo_cnt", tmo_cnt1, 1);
    chk("tmo_no_done", done_cnt1, 0);
    chk("tmo_r1_low", r1, 0);
    chk("tmo_busy1_low", busy1, 0);
    $display("txn timeout: tmo_at=%0d tmo_count=%0d", tmo_at1, tmo_cnt1);

    // zero hold with instant grant gives the minimum transaction
    clear_stats(); grant_en = 1'b1; dly = 1;
    hold_len1 = 8'd0; start1 = 1'b1;
    steps(12);
    chk("zero_own_cnt", own_cnt1, 1);
    chk("zero_own_first", own_first1, 4);
    chk("zero_done_at", done_at1, 8);
    $display("txn zero_hold: own_cycles=%0d done_at=%0d", own_cnt1, done_at1);

    // spurious grant on idle channel 2
    clear_stats(); grant_en = 1'b0; force_g2 = 1'b1; g2 = 1'b1;
    steps(4);
    chk("spur_set", err_spur, 1);
    chk("spur_no_both", err_both, 0);
    force_g2 = 1'b0;
    steps(6);
    chk("spur_sticky", err_spur, 1);
    $display("txn spurious: err_spur=%0b", err_spur);

    // both grants high during channel 1 ownership
    clear_stats(); grant_en = 1'b1; dly = 1;
    hold_len1 = 8'd10; start1 = 1'b1;
    steps(6);
    chk("both_pre", err_both, 0);
    force_g2 = 1'b1; g2 = 1'b1;
    steps(4);
    chk("both_set", err_both, 1);
    force_g2 = 1'b0;
    steps(20);
    chk("both_sticky", err_both, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("both_cleared", {30'd0, err_both, err_spur}, 0);
    $display("txn exclusion: err_both set then cleared by reset");

    // reset during ownership
    clear_stats(); dly = 1;
    hold_len1 = 8'd10; start1 = 1'b1;
    steps(6);
    chk("rst_own_before", own1, 1);
    reset = 1'b1;
    step();
    chk("rst_outs", outs(), 32'd0);
    reset = 1'b0;
    steps(10);
    chk("rst_no_done", done_cnt1, 0);
    chk("rst_idle", {30'd0, busy1, err_spur}, 0);
    $display("txn reset_mid_own: done_count=%0d busy1=%0b", done_cnt1, busy1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
